vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//   VGA raster timing generator and the pixel-rate consumer of the master clock. Runs on the
//   50 MHz master clk, derives a one-cycle pixel-enable strobe, and steps horizontal/vertical
//   counters on it. Produces hsync/vsync, a visible-area flag, line/frame start strobes and
//   current pixel coordinates, which drive the Pong renderer and the VGA pins.
// PARAMETERS
//   PIX_DIV   2    clk cycles per pixel; range 1..16 (2 gives 25 MHz pixels at 50 MHz clk)
//   H_VIS     640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   hsync pulse width (pixels)
//   H_BP      48   horizontal back porch; H_TOTAL = 800, must be <= 1024
//   V_VIS     480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vsync pulse width (lines)
//   V_BP      33   vertical back porch; V_TOTAL = 525, must be <= 1024
//   SYNC_POL  0    active level of hsync/vsync (0 = active-low)
// PORTS
//   clk          in   1   master clock, 50 MHz
//   clr          in   1   reset, synchronous, active-high
//   pix_en       out  1   pixel strobe, high 1 clk of every PIX_DIV
//   hcount       out  10  current pixel column, 0..H_TOTAL-1
//   vcount       out  10  current line, 0..V_TOTAL-1
//   hsync        out  1   horizontal sync, SYNC_POL when asserted
//   vsync        out  1   vertical sync, SYNC_POL when asserted
//   video_on     out  1   1 when hcount < H_VIS and vcount < V_VIS
//   line_start   out  1   1-clk strobe, first clk in which hcount = 0
//   frame_start  out  1   1-clk strobe, first clk in which hcount = 0 and vcount = 0
// BEHAVIOUR
//   - Reset (clr high at an edge): div = 0, hcount = H_TOTAL-1, vcount = V_TOTAL-1.
//     hsync/vsync = ~SYNC_POL, video_on = 0, line_start = frame_start = 0.
//     The first pixel step after reset wraps to (0,0). clr overrides pix_en and any counter
//     state. clr asserted mid-frame restarts the same way.
//   - Divider: div counts 0..PIX_DIV-1 and wraps. pix_en = (div == PIX_DIV-1), decoded from a
//     registered div. With PIX_DIV = 1, pix_en is 1 in every cycle after reset.
//   - Counter step (edge with pix_en = 1): hcount += 1. At H_TOTAL-1, hcount -> 0 and vcount += 1.
//     At (H_TOTAL-1, V_TOTAL-1) both wrap to 0. Counters hold between strobes.
//   - hsync, vsync and video_on are registered. They are decoded from the next counter values
//     at the same edge, so they always match the hcount/vcount presented in that cycle
//     (zero relative latency).
//   - hsync is asserted for hcount in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656, 751].
//   - vsync is asserted for vcount in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [490, 491].
//   - line_start and frame_start are set only on the edge where the counter wraps, and are
//     cleared on the next edge. They are 1 clk wide, not PIX_DIV wide.
//   - Latency: after clr falls, the first pix_en occurs PIX_DIV-1 clks later. frame_start
//     rises the following clk.
// STRUCTURE
//   - Shared package vga_timing_pkg holds the default 640x480@60 constants (H_*/V_* above),
//     the derived H_TOTAL/V_TOTAL, and the 10-bit counter width constant.
//   - One sub-module, pix_en_gen: PIX_DIV modulo counter with sync clr, output pix_en.
//   - Remaining logic (h/v counters and registered decode) lives in vga_sync_gen itself.
// TESTING
//   1. Reset release, PIX_DIV=2 -> pix_en high in clk 1, 3, 5... after clr falls.
//      In clk 2: frame_start = line_start = 1, (hcount,vcount) = (0,0), video_on = 1.
//   2. Run one line -> video_on drops at hcount 640. hsync low for hcount 656..751
//      (192 clk). line_start period is 1600 clk.
//   3. Run two frames -> vsync low for vcount 490..491 (3200 clk).
//      frame_start period is 840000 clk, with exactly one pulse per frame.
//   4. Wrap checks: (799,123) -> (0,124) with line_start only.
//      (799,524) -> (0,0) with line_start and frame_start.
//   5. clr pulsed 1 clk at (300,200) -> next clk: (799,524), syncs inactive, video_on = 0,
//      strobes 0. Sequence then repeats test 1.
//   6. PIX_DIV=1 build -> pix_en constant 1 after reset. Line is 800 clk, hsync 96 clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and helpers shared by the VGA sync generator.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  typedef logic [CNT_W-1:0] cnt_t;

  // Inclusive window test used for the sync pulse decodes.
  function automatic logic in_range(input cnt_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing outputs of vga_sync_gen, consumed by the renderer and the VGA pins.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic pix_en;
  cnt_t hcount;
  cnt_t vcount;
  logic hsync;
  logic vsync;
  logic video_on;
  logic line_start;
  logic frame_start;

  modport master (
    output pix_en, hcount, vcount, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    input pix_en, hcount, vcount, hsync, vsync, video_on, line_start, frame_start
  );

endinterface

// File: rtl/vga_sync_gen_pix_en.sv
// Pixel-enable strobe: modulo-PIX_DIV counter, strobe high in its last count.
module pix_en_gen #(
  parameter int PIX_DIV = 2
) (
  input  logic clk,
  input  logic clr,
  output logic pix_en
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (clr) div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else div <= div + DW'(1);
  end

  // With PIX_DIV = 1 div is pinned at zero, so the strobe is permanently high.
  assign pix_en = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters stepped on the pixel strobe, with
// sync/visible flags registered from the next counter values so they align with the counts.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   PIX_DIV  = 2,
  parameter int   H_VIS    = vga_timing_pkg::H_VIS,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_VIS    = vga_timing_pkg::V_VIS,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input logic            clk,
  input logic            clr,
  vga_sync_gen_if.master vga
);

  localparam int   H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int   V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
  localparam int   HS_LO  = H_VIS + H_FP;
  localparam int   HS_HI  = H_VIS + H_FP + H_SYNC - 1;
  localparam int   VS_LO  = V_VIS + V_FP;
  localparam int   VS_HI  = V_VIS + V_FP + V_SYNC - 1;

  logic pix_en;
  cnt_t hcount, vcount;
  cnt_t h_next, v_next;
  logic h_wrap, v_wrap;
  logic hsync, vsync, video_on, line_start, frame_start;

  pix_en_gen #(.PIX_DIV(PIX_DIV)) u_pix_en (
    .clk    (clk),
    .clr    (clr),
    .pix_en (pix_en)
  );

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_next = h_wrap ? '0 : hcount + cnt_t'(1);
    v_next = vcount;
    if (h_wrap) v_next = v_wrap ? '0 : vcount + cnt_t'(1);
  end

  // Reset parks the counters on the last pixel so the first step lands on (0,0).
  always_ff @(posedge clk) begin
    if (clr) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en && h_wrap;
      frame_start <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        hcount   <= h_next;
        vcount   <= v_next;
        hsync    <= in_range(h_next, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
        vsync    <= in_range(v_next, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
        video_on <= (int'(h_next) < H_VIS) && (int'(v_next) < V_VIS);
      end
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.hcount      = hcount;
  assign vga.vcount      = vcount;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.video_on    = video_on;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three builds (default, PIX_DIV=1, small raster)
// share one randomly pulsed clr; expectations come from a pixel-index model.
module tb_vga_sync_gen;

  localparam int NCYC = 60000;

  // Small raster so whole frames and the (last,last) wrap fit in the run.
  localparam int C_PD = 3;
  localparam int C_HV = 16, C_HF = 2, C_HS = 4, C_HB = 3;
  localparam int C_VV = 10, C_VF = 2, C_VS = 2, C_VB = 3;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();
  vga_sync_gen_if if_c ();

  vga_sync_gen #(.PIX_DIV(2)) u_a (.clk(clk), .clr(clr), .vga(if_a));
  vga_sync_gen #(.PIX_DIV(1)) u_b (.clk(clk), .clr(clr), .vga(if_b));
  vga_sync_gen #(
    .PIX_DIV(C_PD),
    .H_VIS(C_HV), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
    .V_VIS(C_VV), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB),
    .SYNC_POL(1'b1)
  ) u_c (.clk(clk), .clr(clr), .vga(if_c));

  obs_t qa[$], qb[$], qc[$];
  int n_checks = 0;
  int n_fail   = 0;

  // k = clk cycles since the last reset edge (0 = cycle right after it).
  // Pixel steps taken so far is k/pd; position is (steps-1) mod frame size.
  function automatic obs_t model(input int k, input int pd,
                                 input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb,
                                 input logic pol);
    obs_t o;
    int ht, vt, steps, p, h, v;
    ht    = hv + hf + hsw + hb;
    vt    = vv + vf + vsw + vb;
    steps = k / pd;
    p     = (steps + ht * vt - 1) % (ht * vt);
    h     = p % ht;
    v     = p / ht;
    o.pix_en = ((k % pd) == pd - 1);
    o.h      = 10'(h);
    o.v      = 10'(v);
    o.hs     = (h >= hv + hf && h < hv + hf + hsw) ? pol : ~pol;
    o.vs     = (v >= vv + vf && v < vv + vf + vsw) ? pol : ~pol;
    o.von    = (h < hv) && (v < vv);
    o.ls     = (steps > 0) && ((k % pd) == 0) && (h == 0);
    o.fs     = o.ls && (v == 0);
    return o;
  endfunction

  task automatic check(input string nm, input obs_t e, input obs_t g);
    n_checks++;
    if (g !== e) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s @%0t: got pix_en=%b h=%0d v=%0d hs=%b vs=%b von=%b ls=%b fs=%b, expected pix_en=%b h=%0d v=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
                 nm, $time, g.pix_en, g.h, g.v, g.hs, g.vs, g.von, g.ls, g.fs,
                 e.pix_en, e.h, e.v, e.hs, e.vs, e.von, e.ls, e.fs);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Stimulus: clr chosen at each negedge for the coming edge; expectation queued.
  initial begin
    int  k;
    int  hold;
    bit  armed;
    k = 0; hold = 0; armed = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc < 3) clr = 1'b1;
      else if (hold > 0) begin clr = 1'b1; hold--; end
      else if ($urandom_range(0, 3999) == 0) begin clr = 1'b1; hold = $urandom_range(0, 2); end
      else clr = 1'b0;
      if (clr) begin k = 0; armed = 1; end
      else k++;
      if (armed) begin
        qa.push_back(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        qb.push_back(model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        qc.push_back(model(k, C_PD, C_HV, C_HF, C_HS, C_HB, C_VV, C_VF, C_VS, C_VB, 1'b1));
      end
    end
    @(negedge clk);
    @(negedge clk);
    check_int("drain_a", qa.size(), 0);
    check_int("drain_b", qb.size(), 0);
    check_int("drain_c", qc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Monitor: sample just after each active edge and compare with the queued expectation.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge clk);
      #2;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        g = {if_a.pix_en, if_a.hcount, if_a.vcount, if_a.hsync, if_a.vsync,
             if_a.video_on, if_a.line_start, if_a.frame_start};
        check("div2_640x480", e, g);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        g = {if_b.pix_en, if_b.hcount, if_b.vcount, if_b.hsync, if_b.vsync,
             if_b.video_on, if_b.line_start, if_b.frame_start};
        check("div1_640x480", e, g);
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        g = {if_c.pix_en, if_c.hcount, if_c.vcount, if_c.hsync, if_c.vsync,
             if_c.video_on, if_c.line_start, if_c.frame_start};
        check("div3_small", e, g);
      end
    end
  end

  initial begin
    #(64'(NCYC) * 20 + 1000);
    $display("FAIL watchdog: run did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
